// File: rtl/read_arbiter.sv
// read_arbiter: round-robin sharing of one read slave among NUM_MASTERS requesters, one transaction at a time.
// Define READ_ARB_TIMEOUT_EN to end a stalled slave access with SLVERR after TIMEOUT_CYCLES.
module read_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_valid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*4-1:0]          m_id,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic [1:0]                        m_resp,
  output logic                              s_valid,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [3:0]                        s_id,
  input  logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic [1:0]                        s_resp,
  output logic                              busy
);
  localparam int IW = $clog2(NUM_MASTERS);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state;
  logic [IW-1:0] ptr, g, pick, idx, nxt_ptr;
  logic found;
`ifdef READ_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`endif
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = IW'((int'(ptr) + i) % NUM_MASTERS);
      if (!found && m_valid[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
    nxt_ptr = (pick == IW'(NUM_MASTERS - 1)) ? '0 : pick + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      g       <= '0;
      m_ready <= '0;
      m_data  <= '0;
      m_resp  <= '0;
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_id    <= '0;
      busy    <= 1'b0;
`ifdef READ_ARB_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          g       <= pick;
          ptr     <= nxt_ptr;
          s_addr  <= m_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          s_id    <= m_id[pick*4 +: 4];
          s_valid <= 1'b1;
          busy    <= 1'b1;
          state   <= ISSUE;
`ifdef READ_ARB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ISSUE: if (s_ready) begin
          s_valid <= 1'b0;
          m_ready <= NUM_MASTERS'(1) << g;
          m_data  <= s_data;
          m_resp  <= s_resp;
          state   <= RESP;
        end
`ifdef READ_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          s_valid <= 1'b0;
          m_ready <= NUM_MASTERS'(1) << g;
          m_data  <= '0;
          m_resp  <= 2'b10;
          state   <= RESP;
        end else cnt <= cnt + 1'b1;
`endif
        RESP: begin
          m_ready <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
